// File: rtl/corelet_pkg.sv
// Shared definitions for the corelet sequencer: instruction bit map, idle word, states.
package corelet_pkg;

  localparam int ACC_B      = 33;
  localparam int CENP_B     = 32;
  localparam int WENP_B     = 31;
  localparam int AP_MSB     = 30;
  localparam int AP_LSB     = 20;
  localparam int CENX_B     = 19;
  localparam int WENX_B     = 18;
  localparam int AX_MSB     = 17;
  localparam int AX_LSB     = 7;
  localparam int OFIFO_RD_B = 6;
  localparam int RELU_B     = 5;
  localparam int IFIFO_WR_B = 4;
  localparam int L0_RD_B    = 3;
  localparam int L0_WR_B    = 2;
  localparam int EXEC_B     = 1;
  localparam int KLOAD_B    = 0;

  localparam int CNT_W = 16;

  // Both SRAMs deselected and write-disabled, no datapath strobes.
  localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WLOAD,
    S_WKER,
    S_WGAP,
    S_XLOAD,
    S_XEXEC,
    S_XDRAIN,
    S_OREAD,
    S_DONE
  } state_e;

endpackage

// File: rtl/corelet_ctrl_phase_counter.sv
// Loadable down-counter; tc_o is high while the count sits at zero (last cycle of a phase).
module phase_counter
  import corelet_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/corelet_ctrl.sv
// Convolution-pass sequencer: per kernel position loads weights, streams activations,
// and drains the output FIFO into psum SRAM, emitting a registered 34-bit instruction.
module corelet_ctrl
  import corelet_pkg::*;
#(
  parameter int          COL     = 8,
  parameter int          ROW     = 8,
  parameter int          LEN_NIJ = 36,
  parameter int          LEN_KIJ = 9,
  parameter logic [10:0] W_BASE  = 11'd1024,
  parameter logic [10:0] X_BASE  = 11'd0,
  parameter logic [10:0] P_BASE  = 11'd0,
  parameter int          GAP_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [3:0]  kij_o,
  output logic [33:0] inst_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d, load_val;
  logic              load, tc;
  logic [10:0]       w_ofs_q, w_ofs_d, p_ofs_q, p_ofs_d;
  logic [3:0]        kij_q, kij_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [33:0]       inst_q, inst_d;

  phase_counter #(.W(CNT_W)) u_phase (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (load),
    .load_val_i (load_val),
    .tc_o       (tc)
  );

  // Next state; phase counter is loaded with (length - 1) on every state change.
  always_comb begin
    state_d  = state_q;
    kij_d    = kij_q;
    w_ofs_d  = w_ofs_q;
    p_ofs_d  = p_ofs_q;
    idx_d    = idx_q + CNT_W'(1);
    load     = 1'b0;
    load_val = '0;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (start_i) begin
          state_d  = S_WLOAD;
          kij_d    = '0;
          w_ofs_d  = '0;
          p_ofs_d  = '0;
          load_val = CNT_W'(COL);
        end
      end
      S_WLOAD:  if (tc) begin state_d = S_WKER;   load_val = CNT_W'(COL - 1);     end
      S_WKER:   if (tc) begin state_d = S_WGAP;   load_val = CNT_W'(GAP_CYC - 1); end
      S_WGAP:   if (tc) begin state_d = S_XLOAD;  load_val = CNT_W'(LEN_NIJ);     end
      S_XLOAD:  if (tc) begin state_d = S_XEXEC;  load_val = CNT_W'(LEN_NIJ - 1); end
      S_XEXEC:  if (tc) begin state_d = S_XDRAIN; load_val = CNT_W'(GAP_CYC - 1); end
      S_XDRAIN: if (tc) begin state_d = S_OREAD;  load_val = CNT_W'(LEN_NIJ);     end
      S_OREAD: begin
        if (tc) begin
          if (kij_q < 4'(LEN_KIJ - 1)) begin
            state_d  = S_WLOAD;
            kij_d    = kij_q + 4'd1;
            w_ofs_d  = w_ofs_q + 11'(COL);
            p_ofs_d  = p_ofs_q + 11'(LEN_NIJ);
            load_val = CNT_W'(COL);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) begin
      load  = 1'b1;
      idx_d = '0;
    end
  end

  // Outputs are decoded from the upcoming state so they register alongside it.
  always_comb begin
    inst_d = INST_IDLE;
    busy_d = !(state_d inside {S_IDLE, S_DONE});
    done_d = (state_d == S_DONE);
    case (state_d)
      S_WLOAD: begin
        if (idx_d < CNT_W'(COL)) begin
          inst_d[CENX_B]        = 1'b0;
          inst_d[AX_MSB:AX_LSB] = W_BASE + w_ofs_d + idx_d[10:0];
        end
        inst_d[L0_WR_B] = (idx_d != '0);
      end
      S_WKER: begin
        inst_d[L0_RD_B] = 1'b1;
        inst_d[KLOAD_B] = 1'b1;
      end
      S_XLOAD: begin
        if (idx_d < CNT_W'(LEN_NIJ)) begin
          inst_d[CENX_B]        = 1'b0;
          inst_d[AX_MSB:AX_LSB] = X_BASE + idx_d[10:0];
        end
        inst_d[L0_WR_B] = (idx_d != '0);
      end
      S_XEXEC: begin
        inst_d[L0_RD_B] = 1'b1;
        inst_d[EXEC_B]  = 1'b1;
      end
      S_OREAD: begin
        inst_d[OFIFO_RD_B] = (idx_d < CNT_W'(LEN_NIJ));
        if (idx_d != '0) begin
          inst_d[CENP_B]        = 1'b0;
          inst_d[WENP_B]        = 1'b0;
          inst_d[AP_MSB:AP_LSB] = P_BASE + p_ofs_d + idx_d[10:0] - 11'd1;
        end
      end
      default: inst_d = INST_IDLE;
    endcase
    inst_d[ACC_B]      = 1'b0;
    inst_d[RELU_B]     = 1'b0;
    inst_d[IFIFO_WR_B] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      kij_q   <= '0;
      w_ofs_q <= '0;
      p_ofs_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      inst_q  <= INST_IDLE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      kij_q   <= kij_d;
      w_ofs_q <= w_ofs_d;
      p_ofs_q <= p_ofs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      inst_q  <= inst_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign kij_o  = kij_q;
  assign inst_o = inst_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Bench for corelet_ctrl: pass-level instruction model plus literal pins on key sequences.
module tb_corelet_ctrl;

  localparam int COL = 8;
  localparam int NIJ = 36;
  localparam int KIJ = 9;
  localparam int GAP = 16;
  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  typedef struct packed {
    logic [33:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  kij;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [3:0]  kij;
  logic [33:0] inst;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int passes = 0;
  bit gap_chk = 1'b0;

  exp_t q[$];

  always #5 clk = ~clk;

  corelet_ctrl dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .start_i(start),
    .busy_o (busy),
    .done_o (done),
    .kij_o  (kij),
    .inst_o (inst)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t busy_entry(input int k);
    exp_t e;
    e.inst = IDLE_W;
    e.busy = 1'b1;
    e.done = 1'b0;
    e.kij  = 4'(k);
    return e;
  endfunction

  // Whole-pass expectation built phase by phase from the sequencing rules.
  task automatic build_pass();
    exp_t e;
    for (int k = 0; k < KIJ; k++) begin
      for (int c = 0; c <= COL; c++) begin
        e = busy_entry(k);
        if (c < COL) begin e.inst[19] = 1'b0; e.inst[17:7] = 11'(1024 + k*COL + c); end
        if (c >= 1) e.inst[2] = 1'b1;
        q.push_back(e);
      end
      for (int c = 0; c < COL; c++) begin
        e = busy_entry(k); e.inst[3] = 1'b1; e.inst[0] = 1'b1; q.push_back(e);
      end
      for (int c = 0; c < GAP; c++) q.push_back(busy_entry(k));
      for (int c = 0; c <= NIJ; c++) begin
        e = busy_entry(k);
        if (c < NIJ) begin e.inst[19] = 1'b0; e.inst[17:7] = 11'(c); end
        if (c >= 1) e.inst[2] = 1'b1;
        q.push_back(e);
      end
      for (int c = 0; c < NIJ; c++) begin
        e = busy_entry(k); e.inst[3] = 1'b1; e.inst[1] = 1'b1; q.push_back(e);
      end
      for (int c = 0; c < GAP; c++) q.push_back(busy_entry(k));
      for (int c = 0; c <= NIJ; c++) begin
        e = busy_entry(k);
        if (c < NIJ) e.inst[6] = 1'b1;
        if (c >= 1) begin e.inst[32] = 1'b0; e.inst[31] = 1'b0; e.inst[30:20] = 11'(k*NIJ + c - 1); end
        q.push_back(e);
      end
    end
    e = busy_entry(KIJ - 1);
    e.busy = 1'b0;
    e.done = 1'b1;
    q.push_back(e);
  endtask

  // Per-cycle compare against the model; an idle cycle with start high queues a pass.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      q.delete();
    end else if (q.size() > 0) begin
      e = q.pop_front();
      chk("model_inst", 64'(inst), 64'(e.inst));
      chk("model_busy", 64'(busy), 64'(e.busy));
      chk("model_done", 64'(done), 64'(e.done));
      chk("model_kij",  64'(kij),  64'(e.kij));
    end else begin
      chk("idle_inst", 64'(inst), 64'(IDLE_W));
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_done", 64'(done), 64'd0);
      if (start) build_pass();
    end
  end

  // Literal pins: pass length, kij order, kij=2 weight reads, kij=1 psum writes, restart gap.
  int        busy_len, kcyc, last_done_cyc;
  logic      prev_busy, prev_ofifo;
  logic [3:0] prev_kij;
  int        kseen[$];
  int        pm[$];
  initial last_done_cyc = -1;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy  = 1'b0;
      prev_ofifo = 1'b0;
      prev_kij   = 4'd0;
    end else begin
      if (busy && !prev_busy) begin
        busy_len = 0;
        kseen.delete();
        pm.delete();
        if (gap_chk) chk("restart_gap", 64'(cyc - last_done_cyc), 64'd2);
      end
      if (busy) begin
        busy_len++;
        if (!prev_busy || kij != prev_kij) begin
          kcyc = 0;
          kseen.push_back(int'(kij));
        end else begin
          kcyc++;
        end
        if (kij == 4'd2 && kcyc < 9) begin
          chk("k2_l0_wr", 64'(inst[2]), (kcyc >= 1) ? 64'd1 : 64'd0);
          chk("k2_cen_x", 64'(inst[19]), (kcyc < 8) ? 64'd0 : 64'd1);
          if (kcyc < 8) chk("k2_a_xmem", 64'(inst[17:7]), 64'(1040 + kcyc));
        end
        if (kij == 4'd1 && inst[32] == 1'b0) begin
          pm.push_back(int'(inst[30:20]));
          chk("k1_wr_after_ofifo", 64'(prev_ofifo), 64'd1);
        end
      end
      if (done) begin
        passes++;
        $display("pass %0d done at cyc %0d: busy %0d cycles, %0d kij values, %0d kij1 pmem writes",
                 passes, cyc, busy_len, kseen.size(), pm.size());
        chk("pass_busy_len", 64'(busy_len), 64'd1431);
        chk("kij_count", 64'(kseen.size()), 64'd9);
        for (int i = 0; i < kseen.size(); i++) chk("kij_order", 64'(kseen[i]), 64'(i));
        chk("k1_pm_count", 64'(pm.size()), 64'd36);
        for (int i = 0; i < pm.size(); i++) chk("k1_pm_addr", 64'(pm[i]), 64'(36 + i));
        last_done_cyc = cyc;
      end
      prev_busy  = busy;
      prev_kij   = kij;
      prev_ofifo = inst[6];
    end
  end

  task automatic wait_xexec(input logic [3:0] k, input string nm);
    int i = 0;
    while (!(kij == k && inst[1] == 1'b1 && busy) && i < 3000) begin
      @(negedge clk);
      i++;
    end
    chk(nm, 64'(kij == k && inst[1] == 1'b1), 64'd1);
  endtask

  task automatic wait_done(input string nm);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!done && i < 3000);
    chk(nm, 64'(done), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_inst", 64'(inst), 64'h1_800C_0000);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_kij",  64'(kij),  64'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Pass aborted by an asynchronous reset during kij=1 execute.
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    @(negedge clk);
    wait_xexec(4'd1, "reach_xexec_k1");
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_rst_inst", 64'(inst), 64'h1_800C_0000);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_done", 64'(done), 64'd0);
    chk("async_rst_kij",  64'(kij),  64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Full pass with a stray start during kij=4 execute.
    repeat (3) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    @(negedge clk);
    wait_xexec(4'd4, "reach_xexec_k4");
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    wait_done("done_pass_stray_start");

    // Start held high across two passes.
    repeat (4) @(posedge clk);
    #2 start = 1'b1;
    wait_done("done_held_1");
    gap_chk = 1'b1;
    wait_done("done_held_2");
    @(posedge clk); #2 start = 1'b0;
    repeat (6) @(negedge clk);
    chk("passes_completed", 64'(passes), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
